// File: rtl/spi_slave_control_pkg.sv
// spi_slave_control_pkg: FSM state encoding and parameter defaults shared by the SPI slave files
package spi_slave_control_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam logic [7:0] DEF_FILL_BYTE = 8'hFF;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer for one asynchronous SPI pin, with rise/fall pulses
module spi_sync_edge #(
  parameter bit INIT = 1'b0
) (
  input  logic I_CLK,
  input  logic I_RESETN,
  input  logic I_PIN,
  output logic O_LEVEL,
  output logic O_RISE,
  output logic O_FALL
);
  logic [2:0] s;
  always_ff @(posedge I_CLK) s <= !I_RESETN ? {3{INIT}} : {s[1:0], I_PIN};
  assign O_LEVEL = s[1];
  assign O_RISE = s[1] & ~s[2];
  assign O_FALL = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave_control.sv
// spi_slave_control: CPHA=0 SPI slave, byte-wide rx valid/ack and one-deep tx holding register.
// Define SPI_SLAVE_ECHO_EN to send the last received word on tx underrun instead of FILL_BYTE.
module spi_slave_control
  import spi_slave_control_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit CPOL = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE = DATA_WIDTH'(DEF_FILL_BYTE)
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_SS_N,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  SPI_MISO_OE,
  input  logic [DATA_WIDTH-1:0] I_TX_DATA,
  input  logic                  I_TX_EN,
  output logic                  O_TX_READY,
  output logic [DATA_WIDTH-1:0] O_RX_DATA,
  output logic                  O_RX_VALID,
  input  logic                  I_RX_ACK,
  output logic                  O_OVERRUN,
  output logic                  O_UNDERRUN,
  input  logic                  I_CLR_FLAGS,
  output logic                  O_BUSY
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_t state;
  logic [DATA_WIDTH-1:0] hold, tx_shift, rx_shift, rx_next, tx_shifted, under_word;
  logic [CW-1:0] bit_cnt;
  logic sclk_rise, sclk_fall, sclk_lvl_unused, ss_lvl, ss_fall, ss_rise_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic sample_edge, shift_edge, tx_bit, load;
  spi_sync_edge #(.INIT(CPOL)) u_sclk (.I_CLK(I_CLK), .I_RESETN(I_RESETN), .I_PIN(SPI_SCLK),
    .O_LEVEL(sclk_lvl_unused), .O_RISE(sclk_rise), .O_FALL(sclk_fall));
  spi_sync_edge #(.INIT(1'b1)) u_ss (.I_CLK(I_CLK), .I_RESETN(I_RESETN), .I_PIN(SPI_SS_N),
    .O_LEVEL(ss_lvl), .O_RISE(ss_rise_unused), .O_FALL(ss_fall));
  spi_sync_edge #(.INIT(1'b0)) u_mosi (.I_CLK(I_CLK), .I_RESETN(I_RESETN), .I_PIN(SPI_MOSI),
    .O_LEVEL(mosi_lvl), .O_RISE(mosi_rise_unused), .O_FALL(mosi_fall_unused));
`ifdef SPI_SLAVE_ECHO_EN
  assign under_word = O_RX_DATA;
`else
  assign under_word = FILL_BYTE;
`endif
  assign sample_edge = CPOL ? sclk_fall : sclk_rise;
  assign shift_edge = CPOL ? sclk_rise : sclk_fall;
  assign tx_bit = MSB_FIRST ? tx_shift[DATA_WIDTH-1] : tx_shift[0];
  assign tx_shifted = MSB_FIRST ? tx_shift << 1 : tx_shift >> 1;
  assign rx_next = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_lvl} : {mosi_lvl, rx_shift[DATA_WIDTH-1:1]};
  // the trailing edge of each completed word preloads the next one, exactly like LOAD
  assign load = state == LOAD || (state == SHIFT && !ss_lvl && shift_edge && bit_cnt == '0);
  assign SPI_MISO_OE = O_BUSY;
  always_ff @(posedge I_CLK) begin
    if (!I_RESETN) begin
      state <= IDLE;
      hold <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      SPI_MISO <= 1'b0;
      O_TX_READY <= 1'b1;
      O_RX_DATA <= '0;
      O_RX_VALID <= 1'b0;
      O_OVERRUN <= 1'b0;
      O_UNDERRUN <= 1'b0;
      O_BUSY <= 1'b0;
    end else begin
      if (I_CLR_FLAGS) begin
        O_OVERRUN <= 1'b0;
        O_UNDERRUN <= 1'b0;
      end
      if (I_RX_ACK) O_RX_VALID <= 1'b0;
      if (I_TX_EN && O_TX_READY) begin
        hold <= I_TX_DATA;
        O_TX_READY <= 1'b0;
      end
      SPI_MISO <= O_BUSY & tx_bit;
      case (state)
        IDLE: if (ss_fall) begin
          state <= LOAD;
          O_BUSY <= 1'b1;
        end
        LOAD: begin
          state <= SHIFT;
          bit_cnt <= '0;
        end
        default: if (ss_lvl) begin
          state <= IDLE;
          O_BUSY <= 1'b0;
        end else if (sample_edge) begin
          rx_shift <= rx_next;
          bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            O_RX_DATA <= rx_next;
            O_RX_VALID <= 1'b1;
            if (O_RX_VALID && !I_RX_ACK) O_OVERRUN <= 1'b1;
          end
        end else if (shift_edge) tx_shift <= tx_shifted;
      endcase
      // an empty holding register leaves O_TX_READY alone so a same-cycle write is kept
      if (load) begin
        tx_shift <= O_TX_READY ? under_word : hold;
        if (O_TX_READY) O_UNDERRUN <= 1'b1;
        else O_TX_READY <= 1'b1;
      end
    end
  end
endmodule
